// File: rtl/game_sprite_control_pkg.sv
// Shared game configuration: screen geometry, coordinate widths and the
// state encoding reused by sprite-style motion controllers.
package game_sprite_control_pkg;

  localparam int X_WIDTH       = 10;
  localparam int Y_WIDTH       = 10;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  // Frame-strobe counters are sized for the 1..255 divider range.
  localparam int CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    SPRITE_CTRL_IDLE   = 3'd0,
    SPRITE_CTRL_FLY    = 3'd1,
    SPRITE_CTRL_SETTLE = 3'd2,
    SPRITE_CTRL_CHECK  = 3'd3,
    SPRITE_CTRL_LOST   = 3'd4
  } sprite_ctrl_state_e;

  function automatic logic is_visible_state(input sprite_ctrl_state_e s);
    return (s == SPRITE_CTRL_FLY) || (s == SPRITE_CTRL_SETTLE) ||
           (s == SPRITE_CTRL_CHECK);
  endfunction

endpackage

// File: rtl/game_sprite_control_frame_divider.sv
// Frame-strobe counter: counts qualified steps and flags the step that
// completes a TERMINAL-long period, then wraps to zero.
module game_frame_divider
  import game_sprite_control_pkg::*;
#(
  parameter int unsigned TERMINAL = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic step,
  output logic terminal
);

  localparam logic [CNT_WIDTH-1:0] TC = CNT_WIDTH'(TERMINAL - 1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  assign terminal = (count_q == TC);

  // Clear has priority so a launch always restarts the period cleanly.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = terminal ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_sprite_control.sv
// Sprite motion sequencer: launches from a home point, steps by a captured
// signed velocity every FRAME_DIV frames and retires once off screen.
module game_sprite_control
  import game_sprite_control_pkg::*;
#(
  parameter logic [X_WIDTH-1:0] START_X     = '0,
  parameter logic [Y_WIDTH-1:0] START_Y     = '0,
  parameter int                 DELTA_WIDTH = 4,
  parameter int unsigned        FRAME_DIV   = 2,
  parameter int unsigned        LOST_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          launch,
  input  logic signed [DELTA_WIDTH-1:0] dx,
  input  logic signed [DELTA_WIDTH-1:0] dy,
  input  logic                          frame_strobe,
  input  logic                          sprite_within_screen,
  output logic [X_WIDTH-1:0]            sprite_x,
  output logic [Y_WIDTH-1:0]            sprite_y,
  output logic                          sprite_visible,
  output logic                          busy,
  output logic                          lost
);

  sprite_ctrl_state_e state_q, state_d;
  logic [X_WIDTH-1:0]            sprite_x_q, sprite_x_d;
  logic [Y_WIDTH-1:0]            sprite_y_q, sprite_y_d;
  logic signed [DELTA_WIDTH-1:0] dx_q, dx_d;
  logic signed [DELTA_WIDTH-1:0] dy_q, dy_d;
  logic                          visible_q, visible_d;
  logic                          busy_q, busy_d;
  logic                          lost_q, lost_d;

  logic div_clear, div_step, div_tc;
  logic lost_clear, lost_step, lost_tc;

  function automatic logic [X_WIDTH-1:0] sext_x(input logic signed [DELTA_WIDTH-1:0] d);
    return {{(X_WIDTH - DELTA_WIDTH){d[DELTA_WIDTH-1]}}, d};
  endfunction

  function automatic logic [Y_WIDTH-1:0] sext_y(input logic signed [DELTA_WIDTH-1:0] d);
    return {{(Y_WIDTH - DELTA_WIDTH){d[DELTA_WIDTH-1]}}, d};
  endfunction

  game_frame_divider #(.TERMINAL(FRAME_DIV)) u_step_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (div_clear),
    .step     (div_step),
    .terminal (div_tc)
  );

  game_frame_divider #(.TERMINAL(LOST_FRAMES)) u_lost_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (lost_clear),
    .step     (lost_step),
    .terminal (lost_tc)
  );

  always_comb begin
    state_d    = state_q;
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    lost_d     = 1'b0;
    div_clear  = 1'b0;
    div_step   = 1'b0;
    lost_clear = 1'b0;
    lost_step  = 1'b0;

    case (state_q)
      SPRITE_CTRL_IDLE: begin
        if (launch) begin
          dx_d      = dx;
          dy_d      = dy;
          div_clear = 1'b1;
          state_d   = SPRITE_CTRL_FLY;
        end
      end
      SPRITE_CTRL_FLY: begin
        if (frame_strobe) begin
          div_step = 1'b1;
          if (div_tc) begin
            // Modulo wrap is intended: the display rejects huge coordinates.
            sprite_x_d = sprite_x_q + sext_x(dx_q);
            sprite_y_d = sprite_y_q + sext_y(dy_q);
            state_d    = SPRITE_CTRL_SETTLE;
          end
        end
      end
      SPRITE_CTRL_SETTLE: begin
        state_d = SPRITE_CTRL_CHECK;
      end
      SPRITE_CTRL_CHECK: begin
        if (sprite_within_screen) begin
          state_d = SPRITE_CTRL_FLY;
        end else begin
          state_d    = SPRITE_CTRL_LOST;
          lost_d     = 1'b1;
          lost_clear = 1'b1;
        end
      end
      SPRITE_CTRL_LOST: begin
        if (frame_strobe) begin
          lost_step = 1'b1;
          if (lost_tc) begin
            sprite_x_d = START_X;
            sprite_y_d = START_Y;
            state_d    = SPRITE_CTRL_IDLE;
          end
        end
      end
      default: begin
        state_d = SPRITE_CTRL_IDLE;
      end
    endcase

    visible_d = is_visible_state(state_d);
    busy_d    = (state_d != SPRITE_CTRL_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SPRITE_CTRL_IDLE;
      sprite_x_q <= START_X;
      sprite_y_q <= START_Y;
      dx_q       <= '0;
      dy_q       <= '0;
      visible_q  <= 1'b0;
      busy_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sprite_x_q <= sprite_x_d;
      sprite_y_q <= sprite_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      visible_q  <= visible_d;
      busy_q     <= busy_d;
      lost_q     <= lost_d;
    end
  end

  assign sprite_x       = sprite_x_q;
  assign sprite_y       = sprite_y_q;
  assign sprite_visible = visible_q;
  assign busy           = busy_q;
  assign lost           = lost_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench: three controllers with different start points, each closed
// through a registered 8x8 in-screen model of the sprite display.
module tb_game_sprite_control;
  import game_sprite_control_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_strobe;
  logic signed [3:0] dx, dy;
  logic launch_a, launch_b, launch_c;

  logic [X_WIDTH-1:0] x_a, x_b, x_c;
  logic [Y_WIDTH-1:0] y_a, y_b, y_c;
  logic vis_a, vis_b, vis_c;
  logic busy_a, busy_b, busy_c;
  logic lost_a, lost_b, lost_c;
  logic win_a, win_b, win_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n_lost_a = 0;
  int n_lost_b = 0;
  int n_lost_c = 0;

  always #5 clk = ~clk;

  game_sprite_control #(.START_X(10'd100), .START_Y(10'd50), .DELTA_WIDTH(4),
                        .FRAME_DIV(2), .LOST_FRAMES(3)) u_a (
    .clk(clk), .reset_n(reset_n), .launch(launch_a), .dx(dx), .dy(dy),
    .frame_strobe(frame_strobe), .sprite_within_screen(win_a),
    .sprite_x(x_a), .sprite_y(y_a), .sprite_visible(vis_a), .busy(busy_a), .lost(lost_a));

  game_sprite_control #(.START_X(10'd620), .START_Y(10'd50), .DELTA_WIDTH(4),
                        .FRAME_DIV(1), .LOST_FRAMES(3)) u_b (
    .clk(clk), .reset_n(reset_n), .launch(launch_b), .dx(dx), .dy(dy),
    .frame_strobe(frame_strobe), .sprite_within_screen(win_b),
    .sprite_x(x_b), .sprite_y(y_b), .sprite_visible(vis_b), .busy(busy_b), .lost(lost_b));

  game_sprite_control #(.START_X(10'd2), .START_Y(10'd10), .DELTA_WIDTH(4),
                        .FRAME_DIV(1), .LOST_FRAMES(3)) u_c (
    .clk(clk), .reset_n(reset_n), .launch(launch_c), .dx(dx), .dy(dy),
    .frame_strobe(frame_strobe), .sprite_within_screen(win_c),
    .sprite_x(x_c), .sprite_y(y_c), .sprite_visible(vis_c), .busy(busy_c), .lost(lost_c));

  // Display model: 8x8 sprite fully on a 640x480 screen, one register deep.
  function automatic logic on_screen(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
    return ((int'(x) + 7) < SCREEN_WIDTH) && ((int'(y) + 7) < SCREEN_HEIGHT);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_a <= 1'b0;
      win_b <= 1'b0;
      win_c <= 1'b0;
    end else begin
      win_a <= on_screen(x_a, y_a);
      win_b <= on_screen(x_b, y_b);
      win_c <= on_screen(x_c, y_c);
    end
  end

  always @(posedge clk) begin
    if (lost_a) n_lost_a++;
    if (lost_b) n_lost_b++;
    if (lost_c) n_lost_c++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
  endtask

  // Strobe followed by enough idle cycles for SETTLE and CHECK to pass.
  task automatic strobe_gap();
    strobe();
    gap(3);
  endtask

  initial begin
    reset_n = 1'b0; frame_strobe = 1'b0; dx = '0; dy = '0;
    launch_a = 1'b0; launch_b = 1'b0; launch_c = 1'b0;

    // Reset holds with strobes toggling.
    for (int i = 0; i < 4; i++) begin
      frame_strobe = ~frame_strobe;
      tick();
    end
    frame_strobe = 1'b0;
    chk("rst_x_a", int'(x_a), 100);
    chk("rst_y_a", int'(y_a), 50);
    chk("rst_x_b", int'(x_b), 620);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_vis_a", int'(vis_a), 0);
    chk("rst_lost_a", int'(lost_a), 0);
    reset_n = 1'b1;
    gap(2);

    // Basic flight on A: +3/-2 every 2 strobes.
    dx = 4'sd3; dy = -4'sd2; launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    chk("a_busy_launch", int'(busy_a), 1);
    chk("a_vis_launch", int'(vis_a), 1);
    strobe_gap();
    chk("a_x_after_s1", int'(x_a), 100);
    strobe();
    chk("a_x_after_s2", int'(x_a), 103);
    chk("a_y_after_s2", int'(y_a), 48);
    gap(3);
    // Launch while flying must not recapture the velocity.
    dx = -4'sd1; dy = 4'sd5; launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    strobe_gap();
    strobe();
    chk("a_x_after_s4", int'(x_a), 106);
    chk("a_y_after_s4", int'(y_a), 46);
    gap(3);
    strobe_gap();
    strobe();
    chk("a_x_after_s6", int'(x_a), 109);
    chk("a_y_after_s6", int'(y_a), 44);
    gap(3);
    chk("a_vis_flying", int'(vis_a), 1);
    chk("a_no_lost", n_lost_a, 0);

    // Right-edge exit on B.
    dx = 4'sd7; dy = 4'sd0; launch_b = 1'b1;
    tick();
    launch_b = 1'b0;
    gap(1);
    strobe();
    chk("b_x_627", int'(x_b), 627);
    gap(2);
    chk("b_in_screen_lost", int'(lost_b), 0);
    chk("b_in_screen_vis", int'(vis_b), 1);
    gap(1);
    strobe();
    chk("b_x_634", int'(x_b), 634);
    tick();
    chk("b_lost_early", int'(lost_b), 0);
    tick();
    chk("b_lost_pulse", int'(lost_b), 1);
    chk("b_vis_lost", int'(vis_b), 0);
    chk("b_busy_lost", int'(busy_b), 1);
    tick();
    chk("b_lost_one_cycle", int'(lost_b), 0);
    chk("b_lost_count", n_lost_b, 1);

    // LOST timeout on B with a launch attempt that must be ignored.
    dx = 4'sd1; launch_b = 1'b1;
    tick();
    launch_b = 1'b0;
    chk("b_launch_in_lost", int'(busy_b), 1);
    strobe_gap();
    strobe_gap();
    chk("b_busy_two_strobes", int'(busy_b), 1);
    chk("b_x_held_lost", int'(x_b), 634);
    strobe();
    chk("b_busy_timeout", int'(busy_b), 0);
    chk("b_x_home", int'(x_b), 620);
    chk("b_y_home", int'(y_b), 50);
    gap(3);
    chk("b_stays_idle", int'(busy_b), 0);

    // Left wrap on C.
    dx = -4'sd4; dy = 4'sd0; launch_c = 1'b1;
    tick();
    launch_c = 1'b0;
    gap(1);
    strobe();
    chk("c_x_wrap", int'(x_c), 1022);
    tick();
    tick();
    chk("c_lost_pulse", int'(lost_c), 1);
    chk("c_vis_lost", int'(vis_c), 0);
    gap(2);

    // Asynchronous reset mid-SETTLE on B.
    dx = 4'sd1; dy = 4'sd0; launch_b = 1'b1;
    tick();
    launch_b = 1'b0;
    gap(1);
    strobe();
    chk("b_x_621", int'(x_b), 621);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_x_b", int'(x_b), 620);
    chk("ar_busy_b", int'(busy_b), 0);
    chk("ar_x_a", int'(x_a), 100);
    chk("ar_busy_c", int'(busy_c), 0);
    chk("ar_lost_b", int'(lost_b), 0);
    gap(2);
    reset_n = 1'b1;
    gap(4);
    chk("ar_idle_b", int'(busy_b), 0);
    chk("ar_no_lost_b", n_lost_b, 1);
    chk("c_lost_count", n_lost_c, 1);
    chk("a_lost_count", n_lost_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench timeout");
  end

endmodule
